// File: rtl/shared_reg_arb_pkg.sv
// rtl/shared_reg_arb_pkg.sv - shared state encoding and parameter defaults for shared_reg_arb
package shared_reg_arb_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int NREQ_DEF  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_ACK   = 2'd2
   } state_t;

endpackage

// File: rtl/shared_reg_arb_rr_pick.sv
// rtl/shared_reg_arb_rr_pick.sv - combinational round-robin picker
// Searches req_i starting at (last_i+1) mod NREQ and returns the first hit.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   last_i,
   output logic [NREQ-1:0] win_oh_o,
   output logic [IW-1:0]   win_idx_o
);

   int            k;
   logic [IW-1:0] k_idx;
   logic          found;

   always_comb begin
      win_oh_o  = '0;
      win_idx_o = '0;
      found     = 1'b0;
      k         = 0;
      k_idx     = '0;
      for (int i = 1; i <= NREQ; i++) begin
         k     = (int'(last_i) + i) % NREQ;
         k_idx = IW'(k);
         if (!found && req_i[k_idx]) begin
            found            = 1'b1;
            win_oh_o[k_idx]  = 1'b1;
            win_idx_o        = k_idx;
         end
      end
   end

endmodule

// File: rtl/shared_reg_arb.sv
// rtl/shared_reg_arb.sv - round-robin arbiter guarding one shared write register
// IDLE picks a winner, GRANT commits its data (or defers on clear), ACK pulses and may re-grant on lock.
module shared_reg_arb
   import shared_reg_arb_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NREQ  = NREQ_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NREQ-1:0]   req_i,
   input  logic [NREQ-1:0]   lock_i,
   input  logic [NREQ*WIDTH-1:0] wdata_i,
   input  logic              clr_i,
   output logic [NREQ-1:0]   gnt_o,
   output logic              ack_o,
   output logic [WIDTH-1:0]  q_o,
   output logic              busy_o
);

   localparam int IW = $clog2(NREQ);

   state_t            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              ack_q, ack_d;
   logic [WIDTH-1:0]  q_q, q_d;
   logic [IW-1:0]     last_q, last_d;
   logic [IW-1:0]     win_q, win_d;

   logic [NREQ-1:0]   pick_oh;
   logic [IW-1:0]     pick_idx;
   logic              win_req;
   logic              win_lock;
   logic [WIDTH-1:0]  win_data;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
      .req_i     (req_i),
      .last_i    (last_q),
      .win_oh_o  (pick_oh),
      .win_idx_o (pick_idx)
   );

   assign win_req  = req_i[win_q];
   assign win_lock = lock_i[win_q];
   assign win_data = wdata_i[int'(win_q)*WIDTH +: WIDTH];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         ack_q   <= 1'b0;
         q_q     <= '0;
         last_q  <= IW'(NREQ-1);
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         q_q     <= q_d;
         last_q  <= last_d;
         win_q   <= win_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (|req_i) state_d = ST_GRANT;
         ST_GRANT: begin
            if (!win_req)    state_d = ST_IDLE;
            else if (!clr_i) state_d = ST_ACK;
         end
         ST_ACK:   state_d = (win_lock && win_req) ? ST_GRANT : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // An abort wins over a clear in GRANT: the requester is gone, so nothing is left to defer.
   always_comb begin
      gnt_d  = gnt_q;
      last_d = last_q;
      win_d  = win_q;
      q_d    = clr_i ? '0 : q_q;
      unique case (state_q)
         ST_IDLE: begin
            gnt_d = pick_oh;
            win_d = pick_idx;
         end
         ST_GRANT: begin
            if (!win_req) begin
               gnt_d  = '0;
               last_d = win_q;
            end else if (!clr_i) begin
               q_d = win_data;
            end
         end
         ST_ACK: begin
            if (!(win_lock && win_req)) begin
               gnt_d  = '0;
               last_d = win_q;
            end
         end
         default: gnt_d = '0;
      endcase
      ack_d = (state_d == ST_ACK);
   end

   assign gnt_o  = gnt_q;
   assign ack_o  = ack_q;
   assign q_o    = q_q;
   assign busy_o = (state_q != ST_IDLE);

endmodule

// File: doc/shared_reg_arb.md
SHARED_REG_ARB -- requirements
Module: shared_reg_arb

Interface
REQ-001 Parameter WIDTH, default 8, width of the shared register (legal 1..32).
REQ-002 Parameter NREQ, default 4, number of requesters (legal 2..8).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 req_i  input  NREQ  per-requester write request, level, held until served.
REQ-006 lock_i  input  NREQ  per-requester grant hold for back-to-back writes.
REQ-007 wdata_i  input  NREQ*WIDTH  packed write data; requester k at bits [k*WIDTH +: WIDTH].
REQ-008 clr_i  input  1  synchronous clear of the shared register.
REQ-009 gnt_o  output  NREQ  registered one-hot grant, or all zero.
REQ-010 ack_o  output  1  one-cycle pulse: granted write committed.
REQ-011 q_o  output  WIDTH  current shared register value.
REQ-012 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states: IDLE, GRANT, ACK; registered state, gnt_o, ack_o, q_o.
REQ-014 IDLE: if any req_i bit set, pick winner round-robin starting at (last+1) mod NREQ, set gnt_o one-hot to winner, go to GRANT; else stay IDLE with gnt_o = 0.
REQ-015 GRANT, req_i[winner]=1, clr_i=0: q_o <= winner's wdata_i slice at this edge; go to ACK; ack_o = 1 during ACK.
REQ-016 GRANT, req_i[winner]=0: write aborted, q_o unchanged, no ack_o, last <= winner, gnt_o <= 0, go to IDLE.
REQ-017 GRANT with clr_i=1: q_o <= 0, write deferred, stay in GRANT with gnt_o held.
REQ-018 clr_i=1 in IDLE or ACK: q_o <= 0; FSM and gnt_o sequence unaffected.
REQ-019 ACK: gnt_o stays asserted; if lock_i[winner] and req_i[winner] both 1, go to GRANT with same winner (last unchanged); else last <= winner, gnt_o <= 0, go to IDLE.
REQ-020 Latency: req_i rises in IDLE at edge n -> gnt_o high after edge n+1 -> q_o updated and ack_o high after edge n+2.
REQ-021 Unlocked throughput: one write per 3 cycles (GRANT, ACK, IDLE); locked: one write per 2 cycles.
REQ-022 Pointer wrap: after winner NREQ-1, search restarts at requester 0.
REQ-023 Requests from non-winners while busy are ignored until IDLE; never dropped while held.
REQ-024 At most one gnt_o bit high in any cycle; ack_o never high in IDLE or GRANT.

Reset
REQ-025 rst_i=1 at an edge: state IDLE, gnt_o 0, ack_o 0, q_o 0, last = NREQ-1 (requester 0 has first priority).
REQ-026 Reset mid-transaction (GRANT or ACK) discards the pending write; no ack_o in the following cycle.
REQ-027 rst_i has priority over clr_i and all requests.

Structure
REQ-028 Shared package holds the state encoding (2-bit, IDLE=0, GRANT=1, ACK=2) and the WIDTH/NREQ defaults.
REQ-029 One combinational sub-module rr_pick (inputs req vector and last index; outputs one-hot winner and its index) is instantiated once.

Verification (WIDTH=8, NREQ=4)
REQ-030 Single request: after reset, req_i=0001, wdata_i[7:0]=0xA5 -> gnt_o=0001 one cycle later, next cycle q_o=0xA5 and ack_o=1, then IDLE with busy_o=0.
REQ-031 Fairness: req_i=1111 held, distinct data 0x10/0x20/0x30/0x40 -> grant order 0,1,2,3,0; q_o follows the same order.
REQ-032 Lock: lock_i=0100, req_i=0101 held -> requester 2 gets three consecutive writes (2-cycle spacing); after lock_i drops, requester 0 is served next.
REQ-033 Abort: req_i[1] drops during GRANT -> q_o unchanged, no ack_o, next pick starts at requester 2.
REQ-034 Clear collision: clr_i=1 during GRANT with wdata 0x7E -> q_o=0x00, state held; clr_i=0 next cycle -> q_o=0x7E, ack_o=1.
REQ-035 Reset in ACK and pointer wrap: rst_i during ACK -> all outputs 0 and the next grant goes to requester 0; req_i=1001 with last=3 -> requester 0 wins.
